syndrome_round_filter: RTL and testbench
========================================

Name: syndrome_round_filter

Overview:
- Upstream conditioning stage in front of the 3-qubit QEC syndrome decoder.
- Collects ROUNDS repeated 3-bit stabilizer measurement rounds and produces one majority-voted syndrome per group.
- Flags groups where the rounds disagree, i.e. measurement noise.
- Delivers the filtered syndrome over a valid/ready handshake and keeps a saturating count of unstable groups.

Parameters:
- ROUNDS, 3, rounds voted per syndrome; odd, legal range 3..7.
- CNT_W, 8, width of the unstable-group counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- meas_valid  input  1  raw measurement round present on meas_bits.
- meas_bits  input  3  one round of stabilizer outcomes, bit i = check i.
- meas_ready  output  1  block accepts a round this cycle.
- flush  input  1  discard the partially collected group.
- syn_valid  output  1  filtered syndrome available.
- syn_ready  input  1  downstream decoder consumes the syndrome.
- syndrome  output  3  majority-voted syndrome.
- syn_unstable  output  1  rounds in this group disagreed on at least one bit.
- meas_err_count  output  CNT_W  saturating count of unstable groups produced.
- round_idx  output  3  rounds accepted so far in the current group.

Behaviour:
- Reset is synchronous, sampled on the clk edge, and takes priority over all other inputs.
- Reset values:
  - state = COLLECT.
  - syn_valid = 0, syndrome = 000, syn_unstable = 0.
  - meas_err_count = 0, round_idx = 0.
  - Per-bit ones accumulators = 0.
- Reset mid-group discards all collected rounds.
- FSM has two states: COLLECT and HOLD.
- meas_ready = (state == COLLECT) && !flush. This is combinational, and it is the only combinational input-to-output path.
- Accept = meas_valid && meas_ready.
- COLLECT, on accept:
  - ones[i] += meas_bits[i] for each bit; accumulators are 3 bits wide.
  - round_idx += 1.
  - Cycles with meas_valid = 0 leave all state unchanged; gaps are allowed.
- COLLECT, on the accept that completes round ROUNDS (round_idx == ROUNDS-1 before the edge), the same edge does all of the following:
  - syndrome[i] <= (ones_next[i] > ROUNDS/2), where ones_next includes the current beat.
  - syn_unstable <= 1 if any ones_next[i] is neither 0 nor ROUNDS.
  - meas_err_count += 1 when unstable, saturating at all-ones and never wrapping.
  - Accumulators and round_idx cleared to 0.
  - syn_valid <= 1, state <= HOLD.
- Latency: syn_valid rises the cycle after the final accept.
- HOLD:
  - meas_ready = 0.
  - syndrome, syn_unstable and syn_valid are held stable until syn_ready = 1.
  - On syn_valid && syn_ready: syn_valid <= 0, state <= COLLECT. syndrome and syn_unstable keep their last values.
  - The earliest next accept is the cycle after the handshake.
  - Minimum period is ROUNDS + 1 cycles per syndrome.
- flush:
  - In COLLECT: clears accumulators and round_idx on that edge. Any meas_valid in the same cycle is not accepted, because meas_ready = 0.
  - In HOLD: ignored; the committed syndrome is still delivered.
  - flush together with the final beat: flush wins, nothing is produced, and the group is discarded.
- syn_ready while syn_valid = 0 has no effect.
- meas_err_count is cleared only by reset.

Test Plan:
1. ROUNDS=3: three accepted rounds of 011, syn_ready = 1 → the cycle after the third accept, syn_valid = 1, syndrome = 011, syn_unstable = 0, meas_err_count = 0; syn_valid drops the next cycle.
2. ROUNDS=3: rounds 101, 001, 100 → syndrome = 101, syn_unstable = 1, meas_err_count = 1.
3. Backpressure: after a group completes, hold syn_ready = 0 for 5 cycles while driving meas_valid = 1 → syn_valid and syndrome stay stable, meas_ready = 0, round_idx stays 0; raising syn_ready completes the handshake, and the next round is accepted one cycle later.
4. Flush: accept 111 and 111, assert flush for one cycle, then accept 110 three times → only syndrome 110 is produced, with syn_unstable = 0; flush asserted together with meas_valid shows meas_ready = 0.
5. Saturation, CNT_W = 2: four unstable groups (each 100, 000, 000) → meas_err_count reads 1, 2, 3, 3; each syndrome = 000.
6. Reset mid-group: accept two rounds of 111, pulse rst_n = 0 → all outputs at reset values; then three rounds of 010 → syndrome = 010, meas_err_count = 0; also cover ROUNDS = 5 with 1,1,0,0,1 on bit 0 → bit 0 = 1, unstable.

Source files
------------

// File: rtl/syndrome_round_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : syndrome_round_filter_if
// Purpose  : Measurement-in / syndrome-out bundle for syndrome_round_filter.
// Revision : 1.0  initial release
// ============================================================================
interface syndrome_round_filter_if #(
    parameter int CNT_W = 8
);
    logic             meas_valid;
    logic [2:0]       meas_bits;
    logic             meas_ready;
    logic             flush;
    logic             syn_valid;
    logic             syn_ready;
    logic [2:0]       syndrome;
    logic             syn_unstable;
    logic [CNT_W-1:0] meas_err_count;
    logic [2:0]       round_idx;

    // Filter side: consumes rounds, produces syndromes.
    modport slave (
        input  meas_valid,
        input  meas_bits,
        input  flush,
        input  syn_ready,
        output meas_ready,
        output syn_valid,
        output syndrome,
        output syn_unstable,
        output meas_err_count,
        output round_idx
    );

    // Environment side: supplies rounds, consumes syndromes.
    modport master (
        output meas_valid,
        output meas_bits,
        output flush,
        output syn_ready,
        input  meas_ready,
        input  syn_valid,
        input  syndrome,
        input  syn_unstable,
        input  meas_err_count,
        input  round_idx
    );
endinterface
`default_nettype wire

// File: rtl/syndrome_round_filter.sv
`default_nettype none
// ============================================================================
// Module   : syndrome_round_filter
// Purpose  : Majority-votes ROUNDS 3-bit stabilizer rounds into one syndrome,
//            flags noisy groups and counts them (saturating).
// Revision : 1.0  initial release
// ============================================================================
module syndrome_round_filter #(
    parameter int ROUNDS = 3,   // odd, 3..7
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    syndrome_round_filter_if.slave bus
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [2:0]       LAST_IDX   = 3'(ROUNDS - 1);
    localparam logic [2:0]       ALL_ROUNDS = 3'(ROUNDS);
    localparam logic [2:0]       HALF       = 3'(ROUNDS / 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0][2:0]  ones_q, ones_d;
    logic [2:0][2:0]  w_ones_next;
    logic [2:0]       round_idx_q, round_idx_d;
    logic [2:0]       syndrome_q, syndrome_d;
    logic             unstable_q, unstable_d;
    logic             syn_valid_q, syn_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       w_vote;
    logic [2:0]       w_mixed;
    logic             w_meas_ready;
    logic             w_accept;
    logic             w_last_beat;
    logic             w_group_unstable;
    logic             w_cnt_sat;

    // Per-check accumulation including the beat currently offered.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bit
            assign w_ones_next[gi] = ones_q[gi] + {2'b00, bus.meas_bits[gi]};
            assign w_vote[gi]      = (w_ones_next[gi] > HALF);
            assign w_mixed[gi]     = (w_ones_next[gi] != 3'd0) &&
                                     (w_ones_next[gi] != ALL_ROUNDS);
        end
    endgenerate

    assign w_meas_ready     = (state_q == COLLECT) && !bus.flush;
    assign w_accept         = bus.meas_valid && w_meas_ready;
    assign w_last_beat      = w_accept && (round_idx_q == LAST_IDX);
    assign w_group_unstable = |w_mixed;
    assign w_cnt_sat        = &cnt_q;

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        round_idx_d = round_idx_q;
        syndrome_d  = syndrome_q;
        unstable_d  = unstable_q;
        syn_valid_d = syn_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            COLLECT: begin
                if (bus.flush) begin
                    // Flush beats any beat offered alongside it, including the last.
                    ones_d      = '0;
                    round_idx_d = 3'd0;
                end else if (w_last_beat) begin
                    syndrome_d  = w_vote;
                    unstable_d  = w_group_unstable;
                    if (w_group_unstable && !w_cnt_sat) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    ones_d      = '0;
                    round_idx_d = 3'd0;
                    syn_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (w_accept) begin
                    ones_d      = w_ones_next;
                    round_idx_d = round_idx_q + 3'd1;
                end
            end
            HOLD: begin
                if (bus.syn_ready) begin
                    syn_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: begin
                state_d     = COLLECT;
                syn_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            ones_q      <= '0;
            round_idx_q <= 3'd0;
            syndrome_q  <= 3'd0;
            unstable_q  <= 1'b0;
            syn_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            round_idx_q <= round_idx_d;
            syndrome_q  <= syndrome_d;
            unstable_q  <= unstable_d;
            syn_valid_q <= syn_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.meas_ready     = w_meas_ready;
    assign bus.syn_valid      = syn_valid_q;
    assign bus.syndrome       = syndrome_q;
    assign bus.syn_unstable   = unstable_q;
    assign bus.meas_err_count = cnt_q;
    assign bus.round_idx      = round_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_syndrome_round_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_syndrome_round_filter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared against a queue-based majority-vote reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_syndrome_round_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_valid, a_flush, a_syn_ready;
    logic [2:0] a_bits;
    logic       c_valid;
    logic [2:0] c_bits;

    int n_checks = 0;
    int n_errors = 0;

    // Instances A (ROUNDS=3, CNT_W=8) and B (ROUNDS=3, CNT_W=2) share stimulus.
    syndrome_round_filter_if #(.CNT_W(8)) if_a ();
    syndrome_round_filter_if #(.CNT_W(2)) if_b ();
    syndrome_round_filter_if #(.CNT_W(8)) if_c ();

    assign if_a.meas_valid = a_valid;
    assign if_a.meas_bits  = a_bits;
    assign if_a.flush      = a_flush;
    assign if_a.syn_ready  = a_syn_ready;
    assign if_b.meas_valid = a_valid;
    assign if_b.meas_bits  = a_bits;
    assign if_b.flush      = a_flush;
    assign if_b.syn_ready  = a_syn_ready;
    assign if_c.meas_valid = c_valid;
    assign if_c.meas_bits  = c_bits;
    assign if_c.flush      = 1'b0;
    assign if_c.syn_ready  = 1'b1;

    syndrome_round_filter #(.ROUNDS(3), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    syndrome_round_filter #(.ROUNDS(3), .CNT_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    syndrome_round_filter #(.ROUNDS(5), .CNT_W(8)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    // Reference model for A/B: a list of collected rounds plus a pending result.
    logic [2:0] m_q[$];
    bit         m_hold;
    logic [2:0] m_syn;
    bit         m_unst;
    int         m_cnt;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_edge();
        int ones;
        if (!rst_n) begin
            m_q.delete(); m_hold = 0; m_syn = 3'd0; m_unst = 0; m_cnt = 0;
        end else if (m_hold) begin
            if (a_syn_ready) m_hold = 0;
        end else if (a_flush) begin
            m_q.delete();
        end else if (a_valid) begin
            m_q.push_back(a_bits);
            if (m_q.size() == 3) begin
                m_unst = 0;
                for (int i = 0; i < 3; i++) begin
                    ones = 0;
                    foreach (m_q[k]) ones += int'(m_q[k][i]);
                    m_syn[i] = (2 * ones > 3);
                    if (ones != 0 && ones != 3) m_unst = 1;
                end
                if (m_unst) m_cnt++;
                m_hold = 1;
                m_q.delete();
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [2:0] b, input logic f, input logic r);
        a_valid = v; a_bits = b; a_flush = f; a_syn_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic round(input logic [2:0] b);
        drive(1'b1, b, 1'b0, 1'b1);
        tick();
    endtask

    task automatic consume();
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        c_valid = 1'b1; c_bits = 3'b111;
        tick(); tick();
        rst_n = 1'b1;
        c_valid = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (if_a.syn_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", if_a.syn_valid); end
        n_checks++; if (if_a.syndrome !== 3'b000) begin n_errors++; $display("FAIL reset_syndrome: got %b want 000", if_a.syndrome); end
        n_checks++; if (if_a.syn_unstable !== 1'b0) begin n_errors++; $display("FAIL reset_unstable: got %b want 0", if_a.syn_unstable); end
        n_checks++; if (if_a.meas_err_count !== 8'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", if_a.meas_err_count); end
        n_checks++; if (if_a.round_idx !== 3'd0) begin n_errors++; $display("FAIL reset_round_idx: got %0d want 0", if_a.round_idx); end
        n_checks++; if (if_a.meas_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", if_a.meas_ready); end
        n_checks++; if (if_c.round_idx !== 3'd0) begin n_errors++; $display("FAIL reset_c_round_idx: got %0d want 0", if_c.round_idx); end
    endtask

    // ROUNDS=5: bit0 = 1,1,0,0,1 (majority 1, mixed); bit1 always 1.
    task automatic test_rounds5();
        logic [2:0] seq [5] = '{3'b011, 3'b011, 3'b010, 3'b010, 3'b011};
        for (int i = 0; i < 5; i++) begin
            c_valid = 1'b1; c_bits = seq[i];
            @(posedge clk); @(negedge clk);
            if (i == 3) begin
                n_checks++; if (if_c.round_idx !== 3'd4) begin n_errors++; $display("FAIL r5_round_idx: got %0d want 4", if_c.round_idx); end
            end
        end
        c_valid = 1'b0;
        n_checks++; if (if_c.syn_valid !== 1'b1) begin n_errors++; $display("FAIL r5_valid: got %b want 1", if_c.syn_valid); end
        n_checks++; if (if_c.syndrome !== 3'b011) begin n_errors++; $display("FAIL r5_syndrome: got %b want 011", if_c.syndrome); end
        n_checks++; if (if_c.syn_unstable !== 1'b1) begin n_errors++; $display("FAIL r5_unstable: got %b want 1", if_c.syn_unstable); end
        n_checks++; if (if_c.meas_err_count !== 8'd1) begin n_errors++; $display("FAIL r5_count: got %0d want 1", if_c.meas_err_count); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (if_c.syn_valid !== 1'b0) begin n_errors++; $display("FAIL r5_valid_drop: got %b want 0", if_c.syn_valid); end
    endtask

    task automatic test_stable();
        for (int i = 0; i < 3; i++) round(3'b011);
        n_checks++; if (if_a.syn_valid !== 1'b1) begin n_errors++; $display("FAIL stable_valid: got %b want 1", if_a.syn_valid); end
        n_checks++; if (if_a.syndrome !== 3'b011) begin n_errors++; $display("FAIL stable_syndrome: got %b want 011", if_a.syndrome); end
        n_checks++; if (if_a.syn_unstable !== 1'b0) begin n_errors++; $display("FAIL stable_unstable: got %b want 0", if_a.syn_unstable); end
        n_checks++; if (if_a.meas_err_count !== 8'd0) begin n_errors++; $display("FAIL stable_count: got %0d want 0", if_a.meas_err_count); end
        consume();
        n_checks++; if (if_a.syn_valid !== 1'b0) begin n_errors++; $display("FAIL stable_valid_drop: got %b want 0", if_a.syn_valid); end
    endtask

    task automatic test_unstable();
        round(3'b101); round(3'b001); round(3'b100);
        n_checks++; if (if_a.syndrome !== 3'b101) begin n_errors++; $display("FAIL unstable_syndrome: got %b want 101", if_a.syndrome); end
        n_checks++; if (if_a.syn_unstable !== 1'b1) begin n_errors++; $display("FAIL unstable_flag: got %b want 1", if_a.syn_unstable); end
        n_checks++; if (if_a.meas_err_count !== 8'd1) begin n_errors++; $display("FAIL unstable_count: got %0d want 1", if_a.meas_err_count); end
        consume();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 3'b110, 1'b0, 1'b0); tick(); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 3'($urandom_range(7)), 1'b0, 1'b0);
            #1;
            n_checks++; if (if_a.meas_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready: got %b want 0", if_a.meas_ready); end
            n_checks++; if (if_a.syn_valid !== 1'b1 || if_a.syndrome !== 3'b110) begin n_errors++; $display("FAIL bp_hold: got valid=%b syn=%b want 1/110", if_a.syn_valid, if_a.syndrome); end
            n_checks++; if (if_a.round_idx !== 3'd0) begin n_errors++; $display("FAIL bp_round_idx: got %0d want 0", if_a.round_idx); end
            tick();
        end
        drive(1'b1, 3'b001, 1'b0, 1'b1);
        tick();
        n_checks++; if (if_a.syn_valid !== 1'b0 || if_a.round_idx !== 3'd0) begin n_errors++; $display("FAIL bp_handshake: got valid=%b idx=%0d want 0/0", if_a.syn_valid, if_a.round_idx); end
        #1;
        n_checks++; if (if_a.meas_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_after: got %b want 1", if_a.meas_ready); end
        tick();
        n_checks++; if (if_a.round_idx !== 3'd1) begin n_errors++; $display("FAIL bp_next_accept: got %0d want 1", if_a.round_idx); end
        round(3'b001); round(3'b001);
        n_checks++; if (if_a.syndrome !== 3'b001 || if_a.syn_valid !== 1'b1) begin n_errors++; $display("FAIL bp_next_group: got syn=%b valid=%b want 001/1", if_a.syndrome, if_a.syn_valid); end
        consume();
    endtask

    task automatic test_flush();
        round(3'b111); round(3'b111);
        drive(1'b1, 3'b111, 1'b1, 1'b1);
        #1;
        n_checks++; if (if_a.meas_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", if_a.meas_ready); end
        tick();
        n_checks++; if (if_a.round_idx !== 3'd0) begin n_errors++; $display("FAIL flush_round_idx: got %0d want 0", if_a.round_idx); end
        round(3'b110); round(3'b110);
        n_checks++; if (if_a.syn_valid !== 1'b0) begin n_errors++; $display("FAIL flush_early: got %b want 0", if_a.syn_valid); end
        round(3'b110);
        n_checks++; if (if_a.syndrome !== 3'b110 || if_a.syn_unstable !== 1'b0) begin n_errors++; $display("FAIL flush_result: got syn=%b unst=%b want 110/0", if_a.syndrome, if_a.syn_unstable); end
        consume();
        round(3'b000); round(3'b000);
        drive(1'b1, 3'b000, 1'b1, 1'b1);
        tick();
        n_checks++; if (if_a.syn_valid !== 1'b0 || if_a.round_idx !== 3'd0) begin n_errors++; $display("FAIL flush_last_beat: got valid=%b idx=%0d want 0/0", if_a.syn_valid, if_a.round_idx); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0; drive(1'b0, 3'd0, 1'b0, 1'b0); tick(); rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            round(3'b100); round(3'b000); round(3'b000);
            n_checks++; if (if_b.meas_err_count !== 2'(sat(g + 1, 3))) begin n_errors++; $display("FAIL sat_count_b: got %0d want %0d", if_b.meas_err_count, sat(g + 1, 3)); end
            n_checks++; if (if_a.meas_err_count !== 8'(g + 1)) begin n_errors++; $display("FAIL sat_count_a: got %0d want %0d", if_a.meas_err_count, g + 1); end
            n_checks++; if (if_b.syndrome !== 3'b000 || if_b.syn_unstable !== 1'b1) begin n_errors++; $display("FAIL sat_syndrome: got syn=%b unst=%b want 000/1", if_b.syndrome, if_b.syn_unstable); end
            consume();
        end
    endtask

    task automatic test_reset_mid();
        round(3'b111); round(3'b111);
        rst_n = 1'b0; drive(1'b0, 3'd0, 1'b0, 1'b0); tick(); rst_n = 1'b1;
        n_checks++; if (if_a.round_idx !== 3'd0 || if_a.meas_err_count !== 8'd0 || if_a.syn_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_state: got idx=%0d cnt=%0d valid=%b want 0/0/0", if_a.round_idx, if_a.meas_err_count, if_a.syn_valid); end
        n_checks++; if (if_a.syndrome !== 3'b000 || if_a.syn_unstable !== 1'b0) begin n_errors++; $display("FAIL rstmid_syndrome: got syn=%b unst=%b want 000/0", if_a.syndrome, if_a.syn_unstable); end
        round(3'b010); round(3'b010); round(3'b010);
        n_checks++; if (if_a.syndrome !== 3'b010 || if_a.syn_unstable !== 1'b0 || if_a.meas_err_count !== 8'd0) begin n_errors++; $display("FAIL rstmid_result: got syn=%b unst=%b cnt=%0d want 010/0/0", if_a.syndrome, if_a.syn_unstable, if_a.meas_err_count); end
        consume();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(3) != 0, 3'($urandom_range(7)), $urandom_range(9) == 0, $urandom_range(1) == 1);
            #1;
            n_checks++; if (if_a.meas_ready !== (!m_hold && !a_flush)) begin n_errors++; $display("FAIL rnd_ready: got %b want %b", if_a.meas_ready, !m_hold && !a_flush); end
            n_checks++; if (if_a.syn_valid !== m_hold || if_b.syn_valid !== m_hold) begin n_errors++; $display("FAIL rnd_valid: got %b/%b want %b", if_a.syn_valid, if_b.syn_valid, m_hold); end
            n_checks++; if (if_a.syndrome !== m_syn || if_a.syn_unstable !== m_unst) begin n_errors++; $display("FAIL rnd_syndrome: got %b/%b want %b/%b", if_a.syndrome, if_a.syn_unstable, m_syn, m_unst); end
            n_checks++; if (if_a.round_idx !== 3'(m_q.size())) begin n_errors++; $display("FAIL rnd_round_idx: got %0d want %0d", if_a.round_idx, m_q.size()); end
            n_checks++; if (if_a.meas_err_count !== 8'(sat(m_cnt, 255)) || if_b.meas_err_count !== 2'(sat(m_cnt, 3))) begin n_errors++; $display("FAIL rnd_count: got %0d/%0d want %0d/%0d", if_a.meas_err_count, if_b.meas_err_count, sat(m_cnt, 255), sat(m_cnt, 3)); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        c_valid = 1'b0; c_bits = 3'd0;
        @(negedge clk);
        test_reset();
        test_rounds5();
        test_stable();
        test_unstable();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
